hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- ID-stage interlock controller, directly upstream of the forwarding unit.
- Detects hazards forwarding cannot cover: load-use, multi-cycle FPU busy, FP register RAW on an in-flight FPU result.
- Drives the IF/ID hold, ID/EX bubble-insert and taken-branch flush controls, so instructions reaching the forwarding stage always have resolvable operands.
- Tracks the single in-flight FPU op with a latency down-counter; keeps a saturating stall counter.

Parameters:
- FPU_LAT, 4, FPU latency in cycles from issue out of ID (legal 1..15).
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_id  in  1  ID holds a real instruction.
- Y_id  in  4  ID source 1 register.
- X_id  in  4  ID source 2 register.
- use_y_id  in  1  ID actually reads Y_id.
- use_x_id  in  1  ID actually reads X_id.
- fp_src_id  in  1  ID sources are F registers.
- fp_op_id  in  1  ID instruction is an FPU op.
- Z_id  in  4  ID destination register.
- MR_ex  in  1  EX instruction is a load.
- RW_ex  in  3  EX write enables; bit 2 F, bit 1 I, bit 0 P.
- Z_ex  in  4  EX destination register.
- br_taken_ex  in  1  branch resolved taken in EX.
- stall_if  out  1  hold PC and IF/ID.
- stall_id  out  1  hold ID.
- bubble_ex  out  1  load NOP into ID/EX.
- flush_id  out  1  squash IF/ID contents.
- fpu_busy  out  1  FPU op in flight.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- State registers:
  - fcnt[3:0]: FPU cycles remaining.
  - fdst[3:0]: FPU destination register.
  - fpend: FPU destination pending.
  - stall_cnt.
- Reset (async, rst_n low): all state registers 0. Control outputs are combinational from state and inputs, so with quiet inputs they are all 0. fpu_busy=0, stall_cnt=0.
- srcmatch(r) = (use_y_id & Y_id==r) | (use_x_id & X_id==r).
- load_use = MR_ex & RW_ex[1] & ~fp_src_id & srcmatch(Z_ex).
- fp_struct = fp_op_id & (fcnt!=0).
- fp_raw = fp_src_id & fpend & srcmatch(fdst).
- hazard = valid_id & (load_use | fp_struct | fp_raw).
- Flush (br_taken_ex=1), which has priority over hazard:
  - flush_id=1, bubble_ex=1, stall_if=0, stall_id=0.
  - No FPU issue that cycle.
  - An FPU op already in flight is older than the branch and continues counting.
- Stall (hazard=1, no flush):
  - stall_if=1, stall_id=1, bubble_ex=1, flush_id=0.
- Otherwise all four control outputs are 0.
- FPU issue = valid_id & fp_op_id & ~hazard & ~br_taken_ex.
  - On issue, next edge: fcnt<=FPU_LAT, fdst<=Z_id, fpend<=1.
- With no issue and fcnt!=0: fcnt decrements each edge. On the edge where fcnt goes 1->0, fpend<=0.
  - Result: an FP reader is released exactly FPU_LAT cycles after issue.
  - Issue cannot coincide with fcnt!=0, because fp_struct blocks it.
- fpu_busy = (fcnt!=0).
- stall_cnt increments on every edge where stall_id=1. It holds at 2^CNT_W-1 and never wraps.
- valid_id=0 produces no stall, regardless of register matches.
- Register 0 has no special treatment; matches on it stall like any other register.
- Reset asserted mid-operation clears fcnt/fpend immediately. The next cycle sees no FP hazard.

Test Plan:
- Reset: hold rst_n=0 with random inputs, MR_ex=0, br_taken_ex=0, fp_op_id=0 -> fpu_busy=0, stall_cnt=0, all control outputs 0. Release -> no change until a hazard is applied.
- Load-use:
  - Setup: MR_ex=1, RW_ex=3'b010, Z_ex=5, valid_id=1, use_y_id=1, Y_id=5 -> stall_if=stall_id=bubble_ex=1 for one cycle.
  - Next cycle, EX holds the bubble with MR_ex=0 -> stalls drop. stall_cnt=1.
  - Repeat with use_y_id=0 -> no stall.
- FPU latency, FPU_LAT=4:
  - Issue an FP op with Z_id=3 at cycle 0 -> fpu_busy=1 for cycles 1-4.
  - Second fp_op_id held from cycle 1 -> stalled in cycles 1-4, issues in cycle 5. stall_cnt=4.
  - Non-FP op with fp_src_id=1, X_id=3, use_x_id=1 -> stalled through cycle 4.
- Flush vs stall: br_taken_ex=1 in the same cycle as a load-use match -> flush_id=1, bubble_ex=1, stall_if=0, stall_cnt unchanged. An FP op in ID that cycle does not issue (fpu_busy stays 0).
- Reset mid-FPU: issue an FP op, assert rst_n=0 at fcnt=2 -> fpu_busy=0 immediately. After release, an FP op in ID issues without stall.
- Saturation: CNT_W=3, hold a load-use hazard for 10 cycles -> stall_cnt reaches 7 and stays at 7.

Source files
------------

// File: rtl/hazard_unit_if.sv
// Bundle between the ID/EX pipeline registers and the hazard unit. The pipeline
// drives the instruction fields and receives the hold, bubble and flush controls.
interface hazard_unit_if #(
  parameter int CNT_W = 16
);
  logic             valid_id;
  logic [3:0]       Y_id;
  logic [3:0]       X_id;
  logic             use_y_id;
  logic             use_x_id;
  logic             fp_src_id;
  logic             fp_op_id;
  logic [3:0]       Z_id;
  logic             MR_ex;
  logic [2:0]       RW_ex;
  logic [3:0]       Z_ex;
  logic             br_taken_ex;
  logic             stall_if;
  logic             stall_id;
  logic             bubble_ex;
  logic             flush_id;
  logic             fpu_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output valid_id, Y_id, X_id, use_y_id, use_x_id, fp_src_id, fp_op_id, Z_id,
           MR_ex, RW_ex, Z_ex, br_taken_ex,
    input  stall_if, stall_id, bubble_ex, flush_id, fpu_busy, stall_cnt
  );

  modport slave (
    input  valid_id, Y_id, X_id, use_y_id, use_x_id, fp_src_id, fp_op_id, Z_id,
           MR_ex, RW_ex, Z_ex, br_taken_ex,
    output stall_if, stall_id, bubble_ex, flush_id, fpu_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// ID-stage interlock: load-use, FPU structural and FP RAW stalls, taken-branch
// flush, a single in-flight FPU op tracker and a saturating stall counter.
module hazard_unit #(
  parameter int FPU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_unit_if.slave hif
);
  logic [3:0]       fcnt_reg, fcnt_next;
  logic [3:0]       fdst_reg, fdst_next;
  logic             fpend_reg, fpend_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic             load_use, fp_struct, fp_raw, hazard, fpu_issue;
  logic             stall_active;
  logic [3:0]       match_reg_tbl [2];
  logic [1:0]       src_match;
  logic             unused_rw;

  // Source-operand compare against the EX destination (0) and the FPU destination (1).
  assign match_reg_tbl[0] = hif.Z_ex;
  assign match_reg_tbl[1] = fdst_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_match
      assign src_match[gi] = (hif.use_y_id && (hif.Y_id == match_reg_tbl[gi])) ||
                             (hif.use_x_id && (hif.X_id == match_reg_tbl[gi]));
    end
  endgenerate

  assign unused_rw = ^{hif.RW_ex[2], hif.RW_ex[0]};

  assign load_use  = hif.MR_ex && hif.RW_ex[1] && !hif.fp_src_id && src_match[0];
  assign fp_struct = hif.fp_op_id && (fcnt_reg != 4'd0);
  assign fp_raw    = hif.fp_src_id && fpend_reg && src_match[1];
  assign hazard    = hif.valid_id && (load_use || fp_struct || fp_raw);
  assign fpu_issue = hif.valid_id && hif.fp_op_id && !hazard && !hif.br_taken_ex;

  // A taken branch outranks any stall: the stalled instruction is being squashed anyway.
  assign stall_active  = hazard && !hif.br_taken_ex;
  assign hif.stall_if  = stall_active;
  assign hif.stall_id  = stall_active;
  assign hif.bubble_ex = stall_active || hif.br_taken_ex;
  assign hif.flush_id  = hif.br_taken_ex;
  assign hif.fpu_busy  = (fcnt_reg != 4'd0);
  assign hif.stall_cnt = cnt_reg;

  always_comb begin
    fcnt_next  = fcnt_reg;
    fdst_next  = fdst_reg;
    fpend_next = fpend_reg;
    if (fpu_issue) begin
      fcnt_next  = 4'(FPU_LAT);
      fdst_next  = hif.Z_id;
      fpend_next = 1'b1;
    end else if (fcnt_reg != 4'd0) begin
      fcnt_next = fcnt_reg - 4'd1;
      if (fcnt_reg == 4'd1) begin
        fpend_next = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (stall_active && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_reg  <= 4'd0;
      fdst_reg  <= 4'd0;
      fpend_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      fcnt_reg  <= fcnt_next;
      fdst_reg  <= fdst_next;
      fpend_reg <= fpend_next;
      cnt_reg   <= cnt_next;
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// Directed plus random bench for hazard_unit; a timeline model (FPU completion
// cycle, saturating counts) supplies every expected value.
module tb_hazard_unit;
  localparam int LAT = 4;

  logic clk;
  logic rst_n;

  hazard_unit_if #(.CNT_W(16)) hif_a ();
  hazard_unit_if #(.CNT_W(3))  hif_b ();

  hazard_unit #(.FPU_LAT(LAT), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .hif(hif_a.slave));
  hazard_unit #(.FPU_LAT(LAT), .CNT_W(3))  dut_b (.clk(clk), .rst_n(rst_n), .hif(hif_b.slave));

  // Second instance (narrow counter) sees exactly the same stimulus.
  assign hif_b.valid_id    = hif_a.valid_id;
  assign hif_b.Y_id        = hif_a.Y_id;
  assign hif_b.X_id        = hif_a.X_id;
  assign hif_b.use_y_id    = hif_a.use_y_id;
  assign hif_b.use_x_id    = hif_a.use_x_id;
  assign hif_b.fp_src_id   = hif_a.fp_src_id;
  assign hif_b.fp_op_id    = hif_a.fp_op_id;
  assign hif_b.Z_id        = hif_a.Z_id;
  assign hif_b.MR_ex       = hif_a.MR_ex;
  assign hif_b.RW_ex       = hif_a.RW_ex;
  assign hif_b.Z_ex        = hif_a.Z_ex;
  assign hif_b.br_taken_ex = hif_a.br_taken_ex;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the FPU result is outstanding while cyc < done_cyc.
  int         cyc = 0;
  int         done_cyc = 0;
  logic [3:0] fdst_m = 4'd0;
  int         cnt_a = 0;
  int         cnt_b = 0;
  logic       e_stall, e_bubble, e_flush, e_issue;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic reads(input logic [3:0] r);
    return (hif_a.use_y_id && hif_a.Y_id == r) || (hif_a.use_x_id && hif_a.X_id == r);
  endfunction

  task automatic compute_exp();
    logic busy, lu, fs, fr, hz;
    busy = (cyc < done_cyc);
    lu = hif_a.MR_ex && hif_a.RW_ex[1] && !hif_a.fp_src_id && reads(hif_a.Z_ex);
    fs = hif_a.fp_op_id && busy;
    fr = hif_a.fp_src_id && busy && reads(fdst_m);
    hz = hif_a.valid_id && (lu || fs || fr);
    e_flush  = hif_a.br_taken_ex;
    e_stall  = hz && !hif_a.br_taken_ex;
    e_bubble = e_stall || e_flush;
    e_issue  = hif_a.valid_id && hif_a.fp_op_id && !hz && !hif_a.br_taken_ex;
  endtask

  task automatic check_all();
    compute_exp();
    chk("stall_if",   32'(hif_a.stall_if),  32'(e_stall));
    chk("stall_id",   32'(hif_a.stall_id),  32'(e_stall));
    chk("bubble_ex",  32'(hif_a.bubble_ex), 32'(e_bubble));
    chk("flush_id",   32'(hif_a.flush_id),  32'(e_flush));
    chk("fpu_busy",   32'(hif_a.fpu_busy),  32'(cyc < done_cyc));
    chk("stall_cnt",  32'(hif_a.stall_cnt), 32'(cnt_a));
    chk("fpu_busy_b", 32'(hif_b.fpu_busy),  32'(cyc < done_cyc));
    chk("stall_cnt3", 32'(hif_b.stall_cnt), 32'(cnt_b));
  endtask

  // One cycle: check at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    compute_exp();
    if (rst_n) begin
      if (e_stall) begin
        cnt_a = (cnt_a < 65535) ? cnt_a + 1 : 65535;
        cnt_b = (cnt_b < 7) ? cnt_b + 1 : 7;
      end
      if (e_issue) begin
        done_cyc = cyc + 1 + LAT;
        fdst_m   = hif_a.Z_id;
      end
    end
    cyc++;
    #1;
    $display("cycle %0d: stall=%0b bubble=%0b flush=%0b busy=%0b cnt=%0d cnt3=%0d",
             cyc - 1, e_stall, e_bubble, e_flush, hif_a.fpu_busy, hif_a.stall_cnt, hif_b.stall_cnt);
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    done_cyc = 0;
    cnt_a = 0;
    cnt_b = 0;
    chk("rst_busy", 32'(hif_a.fpu_busy),  32'd0);
    chk("rst_cnt",  32'(hif_a.stall_cnt), 32'd0);
  endtask

  task automatic quiet();
    hif_a.valid_id = 0; hif_a.Y_id = 0; hif_a.X_id = 0; hif_a.use_y_id = 0;
    hif_a.use_x_id = 0; hif_a.fp_src_id = 0; hif_a.fp_op_id = 0; hif_a.Z_id = 0;
    hif_a.MR_ex = 0; hif_a.RW_ex = 0; hif_a.Z_ex = 0; hif_a.br_taken_ex = 0;
  endtask

  task automatic rand_inputs();
    hif_a.valid_id    = ($urandom_range(3) != 0);
    hif_a.Y_id        = 4'($urandom_range(3));
    hif_a.X_id        = 4'($urandom_range(3));
    hif_a.use_y_id    = 1'($urandom);
    hif_a.use_x_id    = 1'($urandom);
    hif_a.fp_src_id   = 1'($urandom);
    hif_a.fp_op_id    = ($urandom_range(2) == 0);
    hif_a.Z_id        = 4'($urandom_range(3));
    hif_a.MR_ex       = 1'($urandom);
    hif_a.RW_ex       = 3'($urandom);
    hif_a.Z_ex        = 4'($urandom_range(3));
    hif_a.br_taken_ex = ($urandom_range(7) == 0);
  endtask

  initial begin
    quiet();
    rst_n = 1'b0;
    // Reset held with random but hazard-free inputs.
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      hif_a.MR_ex = 0; hif_a.br_taken_ex = 0; hif_a.fp_op_id = 0;
      step();
    end
    rst_n = 1'b1;
    quiet();
    step();
    step();

    // Load-use on register 5, then the bubble, then a non-reading consumer.
    hif_a.MR_ex = 1; hif_a.RW_ex = 3'b010; hif_a.Z_ex = 5;
    hif_a.valid_id = 1; hif_a.use_y_id = 1; hif_a.Y_id = 5;
    step();
    hif_a.MR_ex = 0;
    step();
    chk("lu_cnt", 32'(hif_a.stall_cnt), 32'd1);
    hif_a.MR_ex = 1; hif_a.use_y_id = 0;
    step();
    quiet();

    // FPU latency: issue to F3, a second op waits four cycles, then an F7 reader waits.
    hif_a.valid_id = 1; hif_a.fp_op_id = 1; hif_a.Z_id = 3;
    step();
    hif_a.Z_id = 7;
    for (int i = 0; i < 5; i++) step();
    chk("fpu_cnt", 32'(hif_a.stall_cnt), 32'd5);
    hif_a.fp_op_id = 0; hif_a.fp_src_id = 1; hif_a.use_x_id = 1; hif_a.X_id = 7;
    for (int i = 0; i < 5; i++) step();
    quiet();

    // Taken branch beats a load-use match; the FP op in ID must not issue.
    hif_a.MR_ex = 1; hif_a.RW_ex = 3'b010; hif_a.Z_ex = 2;
    hif_a.valid_id = 1; hif_a.use_x_id = 1; hif_a.X_id = 2;
    hif_a.fp_op_id = 1; hif_a.br_taken_ex = 1;
    step();
    quiet();
    step();
    chk("flush_no_issue", 32'(hif_a.fpu_busy), 32'd0);

    // Reset while fcnt == 2, then an FP op issues straight away.
    hif_a.valid_id = 1; hif_a.fp_op_id = 1; hif_a.Z_id = 9;
    step();
    quiet();
    step();
    step();
    assert_reset();
    step();
    rst_n = 1'b1;
    hif_a.valid_id = 1; hif_a.fp_op_id = 1; hif_a.fp_src_id = 1;
    hif_a.use_y_id = 1; hif_a.Y_id = 9;
    step();
    quiet();
    step();

    // Saturation of the 3-bit counter under a held load-use hazard.
    hif_a.MR_ex = 1; hif_a.RW_ex = 3'b110; hif_a.Z_ex = 0;
    hif_a.valid_id = 1; hif_a.use_y_id = 1; hif_a.Y_id = 0;
    for (int i = 0; i < 10; i++) step();
    chk("sat_cnt3", 32'(hif_b.stall_cnt), 32'd7);
    quiet();

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      if ($urandom_range(59) == 0) assert_reset();
      else rst_n = 1'b1;
      step();
    end
    rst_n = 1'b1;
    quiet();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
